// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/instruction widths, reset PC, fetch states
// and the opcode field position used by fetch and decode.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next fetch address mux: redirect target, squashed-fetch replay, or sequential
// pc+4, plus the misaligned-redirect strobe.
module pc_next_sel #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                 redirect_i,
  input  logic [ADDR_W-1:0]    redirect_pc_i,
  input  logic [ADDR_W-1:0]    pc_i,
  input  logic [ADDR_W-1:0]    pending_pc_i,
  input  logic                 discard_i,
  input  cpu_pkg::fetch_state_e state_i,
  output logic [ADDR_W-1:0]    target_c,
  output logic [ADDR_W-1:0]    pc_plus4_c,
  output logic [ADDR_W-1:0]    next_pc_c,
  output logic                 align_err_c
);

  import cpu_pkg::*;

  always_comb begin
    target_c    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    pc_plus4_c  = pc_i + ADDR_W'(4);
    align_err_c = redirect_i & (|redirect_pc_i[1:0]);
    next_pc_c   = pc_plus4_c;
    // A live redirect always wins over replaying an earlier squashed target.
    if (redirect_i) begin
      next_pc_c = target_c;
    end else if (discard_i && (state_i == REQ)) begin
      next_pc_c = pending_pc_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/ack word fetches to instruction memory,
// holds the fetched word for decode and handles execute-stage redirects.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         imem_req_o,
  output logic [ADDR_W-1:0]            imem_addr_o,
  input  logic                         imem_ack_i,
  input  logic [cpu_pkg::INSTR_W-1:0]  imem_rdata_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [cpu_pkg::INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [ADDR_W-1:0]            pc_plus4_o,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  output logic                         align_err_o
);

  import cpu_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                discard_q, discard_d;
  logic [ADDR_W-1:0]   pending_pc_q, pending_pc_d;
  logic                align_err_q, align_err_d;

  logic [ADDR_W-1:0]   target_c;
  logic [ADDR_W-1:0]   pc_plus4_c;
  logic [ADDR_W-1:0]   next_pc_c;
  logic                align_err_c;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_i          (pc_q),
    .pending_pc_i  (pending_pc_q),
    .discard_i     (discard_q),
    .state_i       (state_q),
    .target_c      (target_c),
    .pc_plus4_c    (pc_plus4_c),
    .next_pc_c     (next_pc_c),
    .align_err_c   (align_err_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      discard_q    <= 1'b0;
      pending_pc_q <= '0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      discard_q    <= discard_d;
      pending_pc_q <= pending_pc_d;
      align_err_q  <= align_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    discard_d    = discard_q;
    pending_pc_d = pending_pc_q;
    align_err_d  = align_err_c;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_i) begin
          fetch_pc_d = next_pc_c;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          if (redirect_i || discard_q) begin
            // Squashed response: re-issue at the new target next cycle.
            fetch_pc_d = next_pc_c;
            discard_d  = 1'b0;
          end else begin
            instr_d = imem_rdata_i;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_i) begin
          // Address must stay stable until ack; remember where to go after.
          discard_d    = 1'b1;
          pending_pc_d = target_c;
        end
      end
      HOLD: begin
        if (redirect_i || instr_ready_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = next_pc_c;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4_c;
  assign align_err_o   = align_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: wait-state memory driver, an
// abstract fetch model compared every cycle, and directed literal checks.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        align_err_o;

  instr_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .align_err_o   (align_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus controls
  bit          cfg_rand  = 1'b0;
  int          cfg_wait  = 0;
  logic        cfg_ready = 1'b1;
  bit          sched_v   = 1'b0;
  logic [31:0] sched_pc  = '0;
  bit          busy      = 1'b0;
  int          wait_left = 0;

  // abstract model: idle / holding a word / fetching (possibly squashed)
  bit          m_idle, m_hold, m_squash, m_align;
  logic [31:0] m_fetch, m_pend, m_instr, m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = $urandom & 32'hFFFF_FFFC;
      1:       t = $urandom;
      2:       t = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: t = 32'($urandom_range(0, 255));
    endcase
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_hold = 1'b0; m_squash = 1'b0; m_align = 1'b0;
    m_fetch = 32'h0; m_pend = 32'h0; m_instr = 32'h0; m_pc = 32'h0;
  endtask

  // What the next rising edge does, given the inputs just chosen.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = redirect_pc_i & 32'hFFFF_FFFC;
    if (m_idle) begin
      m_idle = 1'b0;
      if (redirect_i) m_fetch = tgt;
    end else if (m_hold) begin
      if (redirect_i) begin
        m_hold = 1'b0; m_fetch = tgt;
      end else if (instr_ready_i) begin
        m_hold = 1'b0; m_fetch = m_pc + 32'd4;
      end
    end else if (imem_ack_i) begin
      if (redirect_i) begin
        m_fetch = tgt; m_squash = 1'b0;
      end else if (m_squash) begin
        m_fetch = m_pend; m_squash = 1'b0;
      end else begin
        m_instr = imem_rdata_i; m_pc = m_fetch; m_hold = 1'b1;
      end
    end else if (redirect_i) begin
      m_squash = 1'b1; m_pend = tgt;
    end
    m_align = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  endtask

  // Per-cycle compare against the model, then drive inputs for the next edge.
  always @(negedge clk_i) begin
    if (!rst_i) model_reset();
    chk("req", 32'(imem_req_o), 32'(!m_idle && !m_hold));
    if (!m_idle && !m_hold) chk("addr", imem_addr_o, m_fetch);
    chk("valid", 32'(instr_valid_o), 32'(m_hold));
    chk("instr", instr_o, m_instr);
    chk("pc", pc_o, m_pc);
    chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
    chk("align_err", 32'(align_err_o), 32'(m_align));

    if (!rst_i) begin
      imem_ack_i = 1'b0; imem_rdata_i = '0; busy = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    end else begin
      instr_ready_i = cfg_rand ? ($urandom_range(0, 99) < 70) : cfg_ready;
      if (sched_v) begin
        redirect_i = 1'b1; redirect_pc_i = sched_pc; sched_v = 1'b0;
      end else if (cfg_rand && ($urandom_range(0, 99) < 12)) begin
        redirect_i = 1'b1; redirect_pc_i = rand_target();
      end else begin
        redirect_i = 1'b0; redirect_pc_i = $urandom;
      end
      imem_ack_i = 1'b0; imem_rdata_i = $urandom;
      if (imem_req_o) begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = cfg_rand ? $urandom_range(0, 4) : cfg_wait;
        end
        if (wait_left == 0) begin
          imem_ack_i = 1'b1; imem_rdata_i = mem_word(imem_addr_o); busy = 1'b0;
        end else begin
          wait_left--;
        end
      end else begin
        busy = 1'b0;
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk_i); #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'h0);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_pc4"}, pc_plus4_o, 32'h4);
    chk({tag, "_align"}, 32'(align_err_o), 32'h0);
  endtask

  initial begin
    model_reset();
    rst_i = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = '0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    #3;
    chk_reset_vals("rst0");
    @(posedge clk_i); #2; rst_i = 1'b1;               // cycle 0 (IDLE)

    // zero-wait memory, ready high: one word every two cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_req", 32'(imem_req_o), 32'h1);
      chk("t1_addr", imem_addr_o, 32'(i * 4));
      chk("t1_novalid", 32'(instr_valid_o), 32'h0);
      tick();
      chk("t1_valid", 32'(instr_valid_o), 32'h1);
      chk("t1_pc", pc_o, 32'(i * 4));
      chk("t1_instr", instr_o, mem_word(32'(i * 4)));
    end

    // three wait states on 0xC
    cfg_wait = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_req", 32'(imem_req_o), 32'h1);
      chk("t2_addr", imem_addr_o, 32'hC);
    end
    tick();
    chk("t2_valid", 32'(instr_valid_o), 32'h1);
    chk("t2_instr", instr_o, mem_word(32'hC));

    // decode stalls for five cycles
    cfg_wait = 0; cfg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid", 32'(instr_valid_o), 32'h1);
      chk("t3_pc", pc_o, 32'hC);
      chk("t3_noreq", 32'(imem_req_o), 32'h0);
    end
    cfg_ready = 1'b1;
    tick(); chk("t3_next", imem_addr_o, 32'h10);
    tick(); chk("t3_pc10", pc_o, 32'h10);

    // redirect and ready together in HOLD: redirect wins
    sched_v = 1'b1; sched_pc = 32'h100;
    tick(); chk("t5_addr", imem_addr_o, 32'h100);
    tick(); chk("t5_pc", pc_o, 32'h100);

    // redirect while a fetch of 0x104 waits
    cfg_wait = 3;
    tick(); chk("t4_addr0", imem_addr_o, 32'h104);
    sched_v = 1'b1; sched_pc = 32'h40;
    tick(); cfg_wait = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk("t4_hold_addr", imem_addr_o, 32'h104);
      chk("t4_novalid", 32'(instr_valid_o), 32'h0);
    end
    tick();
    chk("t4_addr40", imem_addr_o, 32'h40);
    chk("t4_dropped", 32'(instr_valid_o), 32'h0);
    tick();
    chk("t4_valid", 32'(instr_valid_o), 32'h1);
    chk("t4_pc", pc_o, 32'h40);

    // misaligned redirect
    sched_v = 1'b1; sched_pc = 32'h41;
    tick();
    chk("t6_align", 32'(align_err_o), 32'h1);
    chk("t6_addr", imem_addr_o, 32'h40);
    tick();
    chk("t6_align_off", 32'(align_err_o), 32'h0);
    chk("t6_pc", pc_o, 32'h40);

    // wrap at the top of the address space
    sched_v = 1'b1; sched_pc = 32'hFFFF_FFFC;
    tick(); chk("t7_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick(); chk("t7_pc4", pc_plus4_o, 32'h0);
    cfg_wait = 3;
    tick(); chk("t7_wrap", imem_addr_o, 32'h0);
    tick(); chk("t8_waiting", 32'(imem_req_o), 32'h1);

    // asynchronous reset in the middle of a wait
    #1 rst_i = 1'b0;
    #1 chk_reset_vals("t8");
    tick(); rst_i = 1'b1;

    // randomized traffic
    cfg_rand = 1'b1;
    repeat (1500) tick();
    #1 rst_i = 1'b0;
    #1 chk("rnd_rst_req", 32'(imem_req_o), 32'h0);
    tick(); rst_i = 1'b1;
    repeat (1500) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main decoder. Owns the program counter and issues word requests to instruction memory over a req/ack handshake that tolerates wait states.
- Holds the fetched instruction and presents it to decode with a valid/ready handshake; `instr_o[31:26]` drives the decoder opcode input.
- Accepts PC redirects from execute (beq taken, j, jal, jr) and squashes any fetch already in flight.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- imem_req_o  out  1  fetch request; once high, held high with a stable address until ack.
- imem_addr_o  out  ADDR_W  word address of the request; bits [1:0] are always 0.
- imem_ack_i  in  1  memory response strobe; may arrive in the same cycle as req.
- imem_rdata_i  in  32  instruction word, valid while ack is high.
- instr_valid_o  out  1  `instr_o` holds a valid instruction.
- instr_ready_i  in  1  decode accepts `instr_o` this cycle.
- instr_o  out  32  held instruction word.
- pc_o  out  ADDR_W  address of `instr_o`.
- pc_plus4_o  out  ADDR_W  `pc_o + 4`, used for the jal link and the branch base.
- redirect_i  in  1  execute requests a change of control flow.
- redirect_pc_i  in  ADDR_W  redirect target.
- align_err_o  out  1  one-cycle pulse when a redirect target has nonzero bits [1:0].

Behaviour:
- Reset (async, `rst_i`=0):
  - state=IDLE; fetch_pc=RESET_PC; `pc_o`=RESET_PC; `instr_o`=0.
  - `instr_valid_o`=0; `imem_req_o`=0; `align_err_o`=0.
  - discard=0; pending_pc=0.
  - Reset asserted mid-fetch abandons the request; memory must tolerate a dropped req.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - `imem_req_o`=0.
  - Next cycle goes to REQ, unconditionally.
- REQ (`imem_req_o`=1, `imem_addr_o`=fetch_pc):
  - ack=0, redirect=1: discard<=1; pending_pc<=target; address does not change.
  - ack=0, redirect=0: stay in REQ.
  - ack=1, discard=0, redirect=0:
    - `instr_o`<=`imem_rdata_i`; `pc_o`<=fetch_pc; `instr_valid_o`<=1; go to HOLD.
  - ack=1, redirect=1: drop the data; fetch_pc<=target; discard<=0; stay in REQ, so the next request goes out the following cycle.
  - ack=1, discard=1, redirect=0: drop the data; fetch_pc<=pending_pc; discard<=0; stay in REQ.
  - Several redirects before ack: the last one wins.
- HOLD (`instr_valid_o`=1; `instr_o` and `pc_o` stable):
  - redirect=1: `instr_valid_o`<=0; fetch_pc<=target; go to REQ. Redirect beats ready when both are high.
  - ready=1, redirect=0: `instr_valid_o`<=0; fetch_pc<=`pc_o`+4; go to REQ.
  - Neither: stay in HOLD indefinitely.
- Redirect target handling:
  - Target is `redirect_pc_i` with bits [1:0] forced to 0.
  - If `redirect_pc_i[1:0]`!=0, `align_err_o`=1 in the following cycle only.
  - A redirect in IDLE is honoured: fetch_pc<=target.
- Arithmetic: +4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC + 4 = 0. No flag is raised on wrap.
- Throughput:
  - Best case is one instruction every 2 cycles (zero-wait memory, ready always high).
  - Latency from req to `instr_valid_o` is ack cycle + 1.
- `pc_plus4_o` is combinational from the `pc_o` register.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W.
  - RESET_PC.
  - Fetch-state enum {IDLE, REQ, HOLD}.
  - INSTR_W=32.
  - Opcode field slice constants OP_MSB=31, OP_LSB=26, shared with the decoder.
- One natural sub-module: `pc_next_sel`, a combinational target mux with alignment check.
  - Inputs: redirect, `redirect_pc`, `pc_o`, pending_pc, discard, state.
  - Outputs: next fetch_pc and the align-error strobe.
  - Everything else stays in `instr_fetch_unit`.

Test Plan:
- Reset, zero-wait memory, ready tied 1:
  - Addresses 0x0, 0x4, 0x8 are requested on cycles 1, 3, 5.
  - `instr_valid_o` is high on cycles 2, 4, 6, with `pc_o` matching each address.
- Memory with 3 wait states:
  - req and `imem_addr_o`=0x4 stay stable for 4 cycles.
  - `instr_o` = returned word the cycle after ack.
- `instr_ready_i`=0 for 5 cycles in HOLD:
  - `instr_o`, `pc_o` and valid stay stable.
  - No new request until ready rises.
- Redirect to 0x40 while REQ waits on 0x8:
  - The 0x8 data is dropped (`instr_valid_o` stays 0).
  - Next request is to 0x40; `pc_o`=0x40 when valid.
- Redirect and ready both high in HOLD at `pc_o`=0x10, target 0x100: next request is to 0x100, not 0x14.
- Redirect to 0x41: `align_err_o` pulses for one cycle and the fetch goes to 0x40.
- Redirect to 0xFFFF_FFFC, then ready: the following request address is 0x0.
- Assert `rst_i` low mid-wait: all outputs go to reset values immediately (asynchronously).
